// File: rtl/switch_debounce_pkg.sv
// Shared constants for the push-button conditioning stage.
package switch_debounce_pkg;
  localparam logic SW_IDLE          = 1'b1;
  localparam int   EVT_LSB          = 0;
  localparam int   LVL_LSB          = 4;
  localparam int   DEBOUNCE_CNT_DEF = 1000000;
endpackage

// File: rtl/sw_debounce_cell.sv
// One button: 2-flop synchroniser, qualification counter, stable level and press pulse.
module sw_debounce_cell
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int CNT_W        = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;

  // Any agreeing cycle clears the count; the terminal value accepts and rewinds,
  // so the counter never passes CNT_LAST.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q     <= SW_IDLE;
      sync2_q     <= SW_IDLE;
      cnt_q       <= '0;
      level_q     <= SW_IDLE;
      level_dly_q <= SW_IDLE;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/switch_debounce.sv
// Debounced button bus for the LED driver plus sticky W1C press flags on the register port.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW       = 4,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int CNT_W        = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_SW-1:0] Switch_raw,
  output logic [NUM_SW-1:0] Switch,
  output logic [NUM_SW-1:0] sw_press,
  input  logic              reg_cs,
  input  logic              reg_wr,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata
);
  logic [NUM_SW-1:0] evt_q, evt_d;
  logic [NUM_SW-1:0] clr;
  logic              unused_wdata;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    sw_debounce_cell #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_cell (
      .Clk    (Clk),
      .Reset  (Reset),
      .raw_i  (Switch_raw[i]),
      .level_o(Switch[i]),
      .press_o(sw_press[i])
    );
  end

  assign unused_wdata = ^reg_wdata[7:NUM_SW];
  assign clr          = (reg_cs && reg_wr) ? reg_wdata[NUM_SW-1:0] : '0;

  // Set is OR'd in after the clear so a same-cycle press survives.
  always_comb begin
    evt_d = (evt_q & ~clr) | sw_press;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) evt_q <= '0;
    else       evt_q <= evt_d;
  end

  always_comb begin
    reg_rdata                       = '0;
    reg_rdata[EVT_LSB +: NUM_SW]    = evt_q;
    reg_rdata[LVL_LSB +: NUM_SW]    = ~Switch;
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench: press pulses checked through a scoreboard queue, levels and registers inline.
module tb_switch_debounce;
  localparam int D = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Switch_raw = 4'hF;
  logic [3:0] Switch, sw_press;
  logic       reg_cs = 1'b0, reg_wr = 1'b0;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int       cyc;
    logic [3:0] v;
  } exp_t;
  exp_t exp_q[$];
  exp_t m_e;

  switch_debounce #(.NUM_SW(4), .DEBOUNCE_CNT(D), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Switch_raw(Switch_raw), .Switch(Switch),
    .sw_press(sw_press), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Monitor: every nonzero press vector must match the queue head at its expected cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      m_e = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL press_missing cyc=%0d got=none want=%b@%0d", cyc, m_e.v, m_e.cyc);
    end
    if (sw_press !== 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL press_unexpected cyc=%0d got=%b want=none", cyc, sw_press);
      end else begin
        m_e = exp_q.pop_front();
        if (m_e.cyc != cyc || m_e.v !== sw_press) begin
          failures++;
          $display("FAIL press cyc=%0d got=%b want=%b@%0d", cyc, sw_press, m_e.v, m_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic wait_neg(input int c);
    do @(negedge Clk); while (cyc < c);
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic reg_write(input logic [7:0] d);
    step();
    reg_cs = 1'b1; reg_wr = 1'b1; reg_wdata = d;
    step();
    reg_cs = 1'b0; reg_wr = 1'b0; reg_wdata = 8'h00;
    @(negedge Clk);
  endtask

  // Press then release one or more buttons, leaving all bits released.
  task automatic tap(input logic [3:0] m);
    int c0;
    step();
    Switch_raw = Switch_raw & ~m;
    c0 = cyc;
    push(c0 + D + 3, m);
    repeat (D + 6) step();
    Switch_raw = 4'hF;
    repeat (D + 6) step();
  endtask

  initial begin
    int c0;
    repeat (3) step();
    @(negedge Clk);
    chk("reset_switch", {4'h0, Switch}, 8'h0F);
    chk("reset_press", {4'h0, sw_press}, 8'h00);
    chk("reset_rdata", reg_rdata, 8'h00);
    step();
    Reset = 1'b0;
    repeat (2) step();

    // Clean press on bit 0.
    Switch_raw[0] = 1'b0;
    c0 = cyc;
    push(c0 + D + 3, 4'b0001);
    wait_neg(c0 + D + 1);  chk("press0_before", {4'h0, Switch}, 8'h0F);
    wait_neg(c0 + D + 2);  chk("press0_level", {4'h0, Switch}, 8'h0E);
    wait_neg(c0 + D + 3);  chk("press0_rd_pre", reg_rdata, 8'h10);
    wait_neg(c0 + D + 4);  chk("press0_rd", reg_rdata, 8'h11);
    step();
    Switch_raw[0] = 1'b1;
    repeat (D + 6) step();
    @(negedge Clk);
    chk("release0_level", {4'h0, Switch}, 8'h0F);
    chk("release0_rd", reg_rdata, 8'h01);

    // Bounce on bit 1: short lows never qualify.
    for (int k = 0; k < 3; k++) begin
      step(); Switch_raw[1] = 1'b0;
      repeat (5) step();
      Switch_raw[1] = 1'b1;
      repeat (4) step();
    end
    repeat (4) step();
    @(negedge Clk);
    chk("bounce_level", {4'h0, Switch}, 8'h0F);
    chk("bounce_rd", reg_rdata, 8'h01);
    step();
    Switch_raw[1] = 1'b0;
    c0 = cyc;
    push(c0 + D + 3, 4'b0010);
    wait_neg(c0 + D + 5);
    chk("hold1_rd", reg_rdata, 8'h23);
    step();
    Switch_raw[1] = 1'b1;
    repeat (D + 6) step();
    @(negedge Clk);
    chk("release1_rd", reg_rdata, 8'h03);

    // W1C.
    reg_write(8'h02);
    chk("w1c_bit1", reg_rdata, 8'h01);
    tap(4'b0100);
    @(negedge Clk);
    chk("evt_0101", reg_rdata, 8'h05);
    reg_write(8'h04);
    chk("w1c_0x04", reg_rdata, 8'h01);
    reg_write(8'hF0);
    chk("w1c_0xF0", reg_rdata, 8'h01);
    reg_write(8'h01);
    chk("w1c_bit0", reg_rdata, 8'h00);

    // Clear of bit 0 lands on the same edge that sets it.
    step();
    Switch_raw[0] = 1'b0;
    c0 = cyc;
    push(c0 + D + 3, 4'b0001);
    while (cyc < c0 + D + 3) step();
    reg_cs = 1'b1; reg_wr = 1'b1; reg_wdata = 8'h01;
    step();
    reg_cs = 1'b0; reg_wr = 1'b0; reg_wdata = 8'h00;
    @(negedge Clk);
    chk("collision_rd", reg_rdata, 8'h11);
    step();
    Switch_raw[0] = 1'b1;
    repeat (D + 6) step();

    // Simultaneous press on bits 2 and 3, then release.
    step();
    Switch_raw[3:2] = 2'b00;
    c0 = cyc;
    push(c0 + D + 3, 4'b1100);
    wait_neg(c0 + D + 2);  chk("multi_level", {4'h0, Switch}, 8'h03);
    wait_neg(c0 + D + 4);  chk("multi_rd", reg_rdata, 8'hCD);
    step();
    Switch_raw = 4'hF;
    repeat (D + 6) step();
    @(negedge Clk);
    chk("multi_release", {4'h0, Switch}, 8'h0F);
    chk("multi_release_rd", reg_rdata, 8'h0D);

    // Async reset in the middle of a qualification on bit 1.
    step();
    Switch_raw[1] = 1'b0;
    repeat (6) step();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_switch", {4'h0, Switch}, 8'h0F);
    chk("async_rst_press", {4'h0, sw_press}, 8'h00);
    chk("async_rst_rd", reg_rdata, 8'h00);
    repeat (3) step();
    @(negedge Clk);
    chk("rst_hold_rd", reg_rdata, 8'h00);
    step();
    Reset = 1'b0;
    c0 = cyc;
    push(c0 + D + 3, 4'b0010);
    wait_neg(c0 + D + 1);  chk("requal_before", {4'h0, Switch}, 8'h0F);
    wait_neg(c0 + D + 2);  chk("requal_level", {4'h0, Switch}, 8'h0D);
    wait_neg(c0 + D + 4);  chk("requal_rd", reg_rdata, 8'h22);
    step();
    Switch_raw = 4'hF;
    repeat (D + 6) step();
    @(negedge Clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL press_queue_empty got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
